// File: rtl/waveform_capture.sv
// Pre/post-trigger waveform capture into a circular buffer, then an oldest-first
// readout of the DEPTH-sample record over a valid/ready stream.
module waveform_capture #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned PRE   = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        trigger,
   input  logic [13:0] outPulse,
   input  logic        arm,
   input  logic        rd_ready,
   output logic        rd_valid,
   output logic [13:0] rd_data,
   output logic        rd_last,
   output logic        busy,
   output logic        done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PreLast   = AW'(PRE - 1);
   localparam logic [AW-1:0] PostLast  = AW'(DEPTH - PRE - 2);
   localparam logic [AW-1:0] PreOff    = AW'(PRE);
   localparam logic [AW-1:0] FetchLast = AW'(DEPTH - 1);

   typedef enum logic [2:0] {StIdle, StPrefill, StWaitTrig, StPost, StReadout} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] start_q, start_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] fetch_q, fetch_d;
   logic          trig_q;
   logic          rd_valid_q, rd_valid_d;
   logic [13:0]   rd_data_q, rd_data_d;
   logic          rd_last_q, rd_last_d;
   logic          done_q, done_d;
   logic          mem_we;
   logic          trig_edge;
   logic [13:0]   mem_q [DEPTH];

   assign trig_edge = trigger & ~trig_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      start_d    = start_q;
      rd_ptr_d   = rd_ptr_q;
      fetch_d    = fetch_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      rd_last_d  = rd_last_q;
      done_d     = 1'b0;
      mem_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arm) begin
               state_d  = StPrefill;
               wr_ptr_d = '0;
               cnt_d    = '0;
            end
         end
         StPrefill: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == PreLast) begin
               state_d = StWaitTrig;
            end
         end
         StWaitTrig: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (trig_edge) begin
               // wr_ptr_q is where the trigger sample lands this cycle
               start_d = wr_ptr_q - PreOff;
               cnt_d   = '0;
               state_d = StPost;
            end
         end
         StPost: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == PostLast) begin
               state_d  = StReadout;
               rd_ptr_d = start_q;
               fetch_d  = '0;
            end
         end
         StReadout: begin
            if (rd_valid_q && rd_ready && rd_last_q) begin
               state_d    = StIdle;
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
               done_d     = 1'b1;
            end else if (!rd_valid_q || rd_ready) begin
               // Refill the output register only when empty or being drained
               rd_valid_d = 1'b1;
               rd_data_d  = mem_q[rd_ptr_q];
               rd_last_d  = (fetch_q == FetchLast);
               rd_ptr_d   = rd_ptr_q + 1'b1;
               fetch_d    = fetch_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         start_q    <= '0;
         rd_ptr_q   <= '0;
         fetch_q    <= '0;
         trig_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         rd_ptr_q   <= rd_ptr_d;
         fetch_q    <= fetch_d;
         trig_q     <= trigger;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_last_q  <= rd_last_d;
         done_q     <= done_d;
      end
   end

   // Buffer contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= outPulse;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_last  = rd_last_q;
   assign busy     = (state_q != StIdle);
   assign done     = done_q;

endmodule
